// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: op codes, FSM states and op classification.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_DIV = 4'd3,
    OP_OR  = 4'd4,
    OP_AND = 4'd5,
    OP_SLL = 4'd6,
    OP_SRL = 4'd7,
    OP_SRA = 4'd8,
    OP_REM = 4'd9,
    OP_XOR = 4'd10,
    OP_SLT = 4'd11
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    DIVI,
    DONE
  } state_t;

  // DIV and REM are the only ops that need the iterative divider.
  function automatic logic is_long_op(alu_op_t op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/alu_iter_div.sv
// Restoring unsigned divider, one quotient bit per cycle, MSB first.
// quot/rem present the values produced by the current step; they are only
// meaningful in the cycle where done is high (the final step).
module alu_iter_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
);

  logic [WIDTH-1:0] quot_q, rem_q, dvsr_q, cnt_q;
  logic [WIDTH-1:0] quot_next, rem_next;
  logic [WIDTH:0]   rem_shift, trial;

  assign busy = (cnt_q != '0);
  assign done = (cnt_q == WIDTH'(1));
  assign quot = quot_next;
  assign rem  = rem_next;

  // One restoring step: shift in the next dividend bit, keep the subtraction if it did not go negative.
  always_comb begin
    rem_shift = {rem_q, quot_q[WIDTH-1]};
    trial     = rem_shift - {1'b0, dvsr_q};
    rem_next  = rem_shift[WIDTH-1:0];
    quot_next = {quot_q[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      rem_next  = trial[WIDTH-1:0];
      quot_next = {quot_q[WIDTH-2:0], 1'b1};
    end
  end

  // Operand latch on start, then WIDTH iterations while the counter runs down to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quot_q <= '0;
      rem_q  <= '0;
      dvsr_q <= '0;
      cnt_q  <= '0;
    end else if (start) begin
      quot_q <= dividend;
      rem_q  <= '0;
      dvsr_q <= divisor;
      cnt_q  <= WIDTH'(WIDTH);
    end else if (busy) begin
      quot_q <= quot_next;
      rem_q  <= rem_next;
      cnt_q  <= cnt_q - WIDTH'(1);
    end
  end

endmodule

// File: rtl/param_mc_alu.sv
// Parametrised multi-cycle ALU with valid/ready handshakes and registered flags.
// Single-cycle ops and divide-by-zero complete in one cycle; DIV/REM take WIDTH+1.
module param_mc_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALUop,
  input  logic             Cin,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Negative,
  output logic             Carry,
  output logic             OverFlow,
  output logic             eq,
  output logic             lt,
  output logic             ltu,
  output logic             div_by_zero,
  output logic             illegal_op
);

  localparam int MSB = WIDTH - 1;

  state_t           state, next_state;
  alu_op_t          op;
  logic             accept, div_start, load_single;
  logic             div_busy, div_done;
  logic [WIDTH-1:0] div_quot, div_rem, div_res;
  logic             pend_rem, pend_eq, pend_lt, pend_ltu;

  logic [WIDTH:0]   add_full, sub_full;
  logic [WIDTH-1:0] mul_lo, res_c;
  logic [SHW-1:0]   sh;
  logic             carry_c, ovf_c, dbz_c, ill_c, eq_c, lt_c, ltu_c;

  assign op        = alu_op_t'(ALUop);
  assign sh        = OpB[SHW-1:0];
  assign add_full  = {1'b0, OpA} + {1'b0, OpB} + {{WIDTH{1'b0}}, Cin};
  assign sub_full  = {1'b0, OpA} + {1'b0, ~OpB} + {{WIDTH{1'b0}}, 1'b1};
  assign mul_lo    = OpA * OpB;
  assign eq_c      = (OpA == OpB);
  assign lt_c      = ($signed(OpA) < $signed(OpB));
  assign ltu_c     = (OpA < OpB);
  assign out_valid = (state == DONE);
  assign div_res   = pend_rem ? div_rem : div_quot;

  alu_iter_div #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (OpA),
    .divisor  (OpB),
    .busy     (div_busy),
    .done     (div_done),
    .quot     (div_quot),
    .rem      (div_rem)
  );

  // Single-cycle result and arithmetic flags; DIV/REM here only cover the divide-by-zero case.
  always_comb begin
    res_c   = '0;
    carry_c = 1'b0;
    ovf_c   = 1'b0;
    dbz_c   = 1'b0;
    ill_c   = 1'b0;
    case (op)
      OP_ADD: begin
        res_c   = add_full[MSB:0];
        carry_c = add_full[WIDTH];
        ovf_c   = (OpA[MSB] == OpB[MSB]) && (add_full[MSB] != OpA[MSB]);
      end
      OP_SUB: begin
        res_c   = sub_full[MSB:0];
        carry_c = sub_full[WIDTH];
        ovf_c   = (OpA[MSB] != OpB[MSB]) && (sub_full[MSB] != OpA[MSB]);
      end
      OP_MUL: res_c = mul_lo;
      OP_DIV: begin
        res_c = '1;
        dbz_c = (OpB == '0);
      end
      OP_REM: begin
        res_c = OpA;
        dbz_c = (OpB == '0);
      end
      OP_OR:  res_c = OpA | OpB;
      OP_AND: res_c = OpA & OpB;
      OP_XOR: res_c = OpA ^ OpB;
      OP_SLL: res_c = OpA << sh;
      OP_SRL: res_c = OpA >> sh;
      OP_SRA: res_c = $signed(OpA) >>> sh;
      OP_SLT: res_c = {{(WIDTH-1){1'b0}}, lt_c};
      default: ill_c = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next state and handshake: DONE with out_ready behaves like IDLE so ops can stream.
  always_comb begin
    next_state  = state;
    div_start   = 1'b0;
    load_single = 1'b0;
    in_ready    = (state == IDLE) || ((state == DONE) && out_ready);
    accept      = in_valid && in_ready;
    case (state)
      IDLE, DONE: begin
        if ((state == DONE) && out_ready) next_state = IDLE;
        if (accept) begin
          if (is_long_op(op) && (OpB != '0)) begin
            next_state = DIVI;
            div_start  = 1'b1;
          end else begin
            next_state  = DONE;
            load_single = 1'b1;
          end
        end
      end
      DIVI: begin
        if (div_done)      next_state = DONE;
        else if (!div_busy) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Remember which divide result to present and the comparisons of the accepted operands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_rem <= 1'b0;
      pend_eq  <= 1'b0;
      pend_lt  <= 1'b0;
      pend_ltu <= 1'b0;
    end else if (div_start) begin
      pend_rem <= (op == OP_REM);
      pend_eq  <= eq_c;
      pend_lt  <= lt_c;
      pend_ltu <= ltu_c;
    end
  end

  // Output registers: loaded on a single-cycle accept or on the final divide step, held otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Result      <= '0;
      Zero        <= 1'b0;
      Negative    <= 1'b0;
      Carry       <= 1'b0;
      OverFlow    <= 1'b0;
      eq          <= 1'b0;
      lt          <= 1'b0;
      ltu         <= 1'b0;
      div_by_zero <= 1'b0;
      illegal_op  <= 1'b0;
    end else if (load_single) begin
      Result      <= res_c;
      Zero        <= !ill_c && (res_c == '0);
      Negative    <= res_c[MSB];
      Carry       <= carry_c;
      OverFlow    <= ovf_c;
      eq          <= !ill_c && eq_c;
      lt          <= !ill_c && lt_c;
      ltu         <= !ill_c && ltu_c;
      div_by_zero <= dbz_c;
      illegal_op  <= ill_c;
    end else if ((state == DIVI) && div_done) begin
      Result      <= div_res;
      Zero        <= (div_res == '0);
      Negative    <= div_res[MSB];
      Carry       <= 1'b0;
      OverFlow    <= 1'b0;
      eq          <= pend_eq;
      lt          <= pend_lt;
      ltu         <= pend_ltu;
      div_by_zero <= 1'b0;
      illegal_op  <= 1'b0;
    end
  end

endmodule
